// File: rtl/apb_tx_fifo_periph.sv
// -----------------------------------------------------------------------------
// apb_tx_fifo_periph
//
// APB subordinate that buffers CPU-written words in a synchronous FIFO and
// drains them on a valid/ready stream to a downstream consumer. Every APB
// transfer takes exactly two ACCESS cycles (one wait state).
//
// Ports
//   PCLK, PRESET      clock (rising edge), synchronous active-high reset
//   PADDR[31:0]       byte address, only [3:2] decoded
//   PWRITE            1 = write, 0 = read
//   PSEL, PENABLE     APB select / ACCESS phase
//   PWDATA[31:0]      write data
//   PRDATA[31:0]      read data, valid while PREADY=1, held otherwise
//   PREADY            transfer completion
//   m_valid           FIFO not empty
//   m_data[DATA_W-1:0] FIFO head word, fall-through
//   m_ready           consumer accepts the head word this cycle
//   irq               low-watermark interrupt, level, registered
//
// Register map (PADDR[3:2])
//   00 CTRL   [0] irq_en, [1] flush (self-clearing, reads 0)
//   01 STATUS [0] empty, [1] full, [2] ovf (W1C), [15:8] count
//   10 TXDATA write pushes PWDATA[DATA_W-1:0], reads 0
//   11 THRESH [7:0] low-watermark
// -----------------------------------------------------------------------------
module apb_tx_fifo_periph #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [31:0]       PADDR,
  input  logic              PWRITE,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              irq
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  localparam logic [1:0] ADDR_CTRL   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_TXDATA = 2'b10;
  localparam logic [1:0] ADDR_THRESH = 2'b11;

  // Registers
  logic              r_pready;
  logic [31:0]       r_prdata;
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic              r_irq_en;
  logic [7:0]        r_thresh;
  logic              r_ovf;
  logic              r_irq;
  logic [DATA_W-1:0] r_mem [DEPTH];

  // Combinational
  logic [1:0]        w_sel;
  logic              w_access_first;
  logic              w_complete;
  logic              w_wr_commit;
  logic [AW:0]       w_count;
  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_flush;
  logic              w_irq_en_next;
  logic [7:0]        w_thresh_next;
  logic              w_ovf_next;
  logic [AW:0]       w_wr_ptr_next;
  logic [AW:0]       w_rd_ptr_next;
  logic [AW:0]       w_count_next;
  logic              w_irq_next;
  logic [31:0]       w_count_ext;
  logic [31:0]       w_rdata;
  logic              w_unused;

  assign w_sel          = PADDR[3:2];
  assign w_access_first = PSEL & PENABLE & ~r_pready;
  // The second ACCESS cycle is the one where PREADY is already high.
  assign w_complete     = PSEL & PENABLE & r_pready;
  assign w_wr_commit    = w_complete & PWRITE;

  // Pointers carry one extra wrap bit, so the difference is the fill level.
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = (w_count == {(AW+1){1'b0}});
  assign w_full  = (w_count == DEPTH_C);
  assign w_pop   = ~w_empty & m_ready;

  assign m_valid = ~w_empty;
  assign m_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign PREADY  = r_pready;
  assign PRDATA  = r_prdata;
  assign irq     = r_irq;

  assign w_count_ext = 32'(w_count);
  assign w_unused    = ^{PADDR, PWDATA};

  // Register write decode and next-state of control/status bits.
  always_comb begin
    w_irq_en_next = r_irq_en;
    w_thresh_next = r_thresh;
    w_ovf_next    = r_ovf;
    w_flush       = 1'b0;
    w_push        = 1'b0;
    if (w_wr_commit) begin
      case (w_sel)
        ADDR_CTRL: begin
          w_irq_en_next = PWDATA[0];
          w_flush       = PWDATA[1];
        end
        ADDR_STATUS: begin
          if (PWDATA[2]) begin
            w_ovf_next = 1'b0;
          end else begin
            w_ovf_next = r_ovf;
          end
        end
        ADDR_TXDATA: begin
          // A same-cycle pop does not make room in a full FIFO.
          if (w_full) begin
            w_ovf_next = 1'b1;
          end else begin
            w_push = 1'b1;
          end
        end
        ADDR_THRESH: begin
          w_thresh_next = PWDATA[7:0];
        end
        default: begin
          w_irq_en_next = r_irq_en;
        end
      endcase
    end else begin
      w_flush = 1'b0;
    end
  end

  // Pointer next-state; flush overrides a same-cycle pop.
  always_comb begin
    w_wr_ptr_next = r_wr_ptr;
    w_rd_ptr_next = r_rd_ptr;
    if (w_flush) begin
      w_wr_ptr_next = {(AW+1){1'b0}};
      w_rd_ptr_next = {(AW+1){1'b0}};
    end else begin
      w_wr_ptr_next = r_wr_ptr + {{AW{1'b0}}, w_push};
      w_rd_ptr_next = r_rd_ptr + {{AW{1'b0}}, w_pop};
    end
  end

  assign w_count_next = w_wr_ptr_next - w_rd_ptr_next;
  assign w_irq_next   = w_irq_en_next & (32'(w_count_next) <= 32'(w_thresh_next));

  // Read data mux, captured on the first ACCESS cycle.
  always_comb begin
    w_rdata = 32'h0000_0000;
    case (w_sel)
      ADDR_CTRL:   w_rdata = {31'h0000_0000, r_irq_en};
      ADDR_STATUS: w_rdata = {16'h0000, w_count_ext[7:0], 5'b00000, r_ovf, w_full, w_empty};
      ADDR_TXDATA: w_rdata = 32'h0000_0000;
      ADDR_THRESH: w_rdata = {24'h00_0000, r_thresh};
      default:     w_rdata = 32'h0000_0000;
    endcase
  end

  // APB handshake, FIFO pointers, control state and interrupt.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_pready <= 1'b0;
      r_prdata <= 32'h0000_0000;
      r_wr_ptr <= {(AW+1){1'b0}};
      r_rd_ptr <= {(AW+1){1'b0}};
      r_irq_en <= 1'b0;
      r_thresh <= 8'h00;
      r_ovf    <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_pready <= w_access_first;
      if (w_access_first) begin
        r_prdata <= w_rdata;
      end
      r_wr_ptr <= w_wr_ptr_next;
      r_rd_ptr <= w_rd_ptr_next;
      r_irq_en <= w_irq_en_next;
      r_thresh <= w_thresh_next;
      r_ovf    <= w_ovf_next;
      r_irq    <= w_irq_next;
    end
  end

  // FIFO storage; contents are deliberately not reset.
  always_ff @(posedge PCLK) begin
    if (w_push && !PRESET) begin
      r_mem[r_wr_ptr[AW-1:0]] <= PWDATA[DATA_W-1:0];
    end
  end

endmodule
